fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
//  Parametrised single-clock synchronous FIFO with register-array storage. No SRAM macro.
//  Generalises the fixed 64x8 modulation FIFO in four ways: configurable width and depth,
//  programmable almost-full/almost-empty thresholds, an exact occupancy count, and
//  overflow/underflow error pulses. Sits between the modulation datapath stages.
// PARAMETERS
//  DATA_W     8    data word width in bits
//  DEPTH      64   number of entries; power of 2, >= 4
//  AF_THRESH  48   almost_full asserts when count >= AF_THRESH (1..DEPTH-1)
//  AE_THRESH  16   almost_empty asserts when count <= AE_THRESH (0..DEPTH-2)
//  Derived: AW = $clog2(DEPTH); CW = AW+1.
// PORTS
//  clk           in   1       clock; all logic on the rising edge
//  reset         in   1       synchronous, active-high reset
//  data_in       in   DATA_W  write data
//  wr_en         in   1       write request
//  rd_en         in   1       read request
//  data_o        out  DATA_W  read data
//  data_valid    out  1       data_o holds a newly read word
//  empty         out  1       count == 0
//  full          out  1       count == DEPTH
//  almost_empty  out  1       count <= AE_THRESH
//  almost_full   out  1       count >= AF_THRESH
//  count         out  CW      current occupancy, 0..DEPTH
//  overflow      out  1       1-cycle pulse: write was rejected
//  underflow     out  1       1-cycle pulse: read was rejected
// BEHAVIOUR
//  - Reset (sync, when reset=1 at a clk edge): wr_ptr=rd_ptr=0; count=0; data_o=0.
//    data_valid=0, overflow=0, underflow=0, empty=1, full=0, almost_empty=1, almost_full=0.
//    The storage array is not cleared.
//  - Reset wins over every other input in the same cycle. A reset mid-stream discards all contents.
//  - Accept rules are evaluated on pre-edge state:
//      rd_acc = rd_en & ~empty
//      wr_acc = wr_en & (~full | rd_acc)
//  - Full plus simultaneous rd/wr: both are accepted; count stays DEPTH.
//  - Empty plus simultaneous rd/wr: the write is accepted, the read is rejected
//    (underflow pulses); count becomes 1.
//  - Writes store mem[wr_ptr] <= data_in; wr_ptr increments.
//    Pointers are AW bits and wrap DEPTH-1 -> 0 with no extra logic.
//  - count update: +1 (wr only), -1 (rd only), unchanged (both or neither).
//    count is never outside 0..DEPTH.
//  - Status flags are combinational decodes of the registered count. They reflect accepted
//    operations the cycle after the edge.
//  - overflow  = registered (wr_en & ~wr_acc)
//  - underflow = registered (rd_en & ~rd_acc)
//  - Read latency, default mode: on rd_acc, data_o <= mem[rd_ptr] and data_valid <= 1 on the
//    same edge, i.e. 1 cycle after rd_en is sampled. Without rd_acc, data_valid <= 0 and
//    data_o holds its previous value.
//  - No state machine; the control is pointer/counter datapath only.
// CONFIGURATION
//  FIFO_FWFT_EN undefined (default):
//    - standard mode; 1-cycle read latency as above.
//  FIFO_FWFT_EN defined (first-word fall-through):
//    - data_o = mem[rd_ptr] combinationally.
//    - data_valid = ~empty.
//    - rd_en acts as an acknowledge: it consumes the displayed word at the edge and the next
//      word appears in the same cycle the pointer moves.
//    - Accept rules, count, flags, and overflow/underflow are identical in both modes.
//    - A write into an empty FIFO makes the word visible 1 cycle after the write edge.
// TESTING
//  1. Reset with DEPTH=64, DATA_W=8 -> count=0, empty=1, almost_empty=1, full=0,
//     data_valid=0, data_o=0.
//  2. Write 0x00..0x3F (64 words) -> full=1 and count=64 after the 64th edge; almost_full
//     first high after the 48th write; a 65th write gives overflow=1 for 1 cycle and count stays 64.
//  3. Read all 64 words -> data_o sequence 0x00..0x3F, each 1 cycle after rd_en
//     (0 cycles with FIFO_FWFT_EN); empty=1 at the end; one extra read gives underflow=1
//     and data_valid=0.
//  4. Fill to 64, then wr_en=rd_en=1 for 10 cycles -> no overflow, count=64, written data
//     read back in order; then from empty, wr_en=rd_en=1 -> underflow=1, count=1.
//  5. Wrap: push 40 words and pop 40, three times (pointers wrap) -> data in order,
//     count 0 at each end, no error pulses.
//  6. Assert reset while count=37 and wr_en=1 -> next cycle count=0, empty=1;
//     the following read gives underflow=1.

Source files
------------

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock synchronous FIFO on a register array.
// Configurable width/depth, almost-full/almost-empty thresholds, an exact
// occupancy count and overflow/underflow error pulses.
// Optional build macro: FIFO_FWFT_EN selects first-word fall-through reads
// (data_o shows mem[rd_ptr] combinationally, data_valid = ~empty).
// Undefined (default): registered read with 1-cycle latency.
module fifo_sync_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = 48,
    parameter int AE_THRESH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    wr_en,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       data_o,
    output logic                    data_valid,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    logic              w_rd_acc;
    logic              w_wr_acc;

    // Status decodes of the registered occupancy.
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CW'(DEPTH));
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_count <= CW'(AE_THRESH));
    assign almost_full  = (r_count >= CW'(AF_THRESH));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A read frees a slot in the same cycle, so a full FIFO still takes a
    // write alongside an accepted read.
    assign w_rd_acc = rd_en & ~w_empty;
    assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

    // Storage write; the array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !reset) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy count and error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_overflow  <= wr_en & ~w_wr_acc;
            r_underflow <= rd_en & ~w_rd_acc;
        end
    end

`ifdef FIFO_FWFT_EN
    // Fall-through read: the head entry is always on the output.
    assign data_o     = r_mem[r_rd_ptr];
    assign data_valid = ~w_empty;
`else
    logic [DATA_W-1:0] r_data_o;
    logic              r_data_valid;

    // Registered read: data_o updates only on an accepted read, else holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_o     <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_o <= r_mem[r_rd_ptr];
            end
        end
    end

    assign data_o     = r_data_o;
    assign data_valid = r_data_valid;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed, table-driven bench for fifo_sync_param
// (DEPTH=64, DATA_W=8, AF=48, AE=16).
module tb_fifo_sync_param;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_o;
    logic       data_valid;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [6:0] count;
    logic       overflow;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    fifo_sync_param #(
        .DATA_W    (8),
        .DEPTH     (64),
        .AF_THRESH (48),
        .AE_THRESH (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .data_o       (data_o),
        .data_valid   (data_valid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit         wr;
        bit         rd;
        logic [7:0] din;
        int         cnt;
        bit         emp;
        bit         ful;
        bit         ovf;
        bit         udf;
        bit         dv;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // One cycle of wr/rd; optionally checks the word a read returns.
    task automatic do_op(input bit wr, input bit rd, input logic [7:0] din,
                         input bit chk_rd, input logic [7:0] exp_d, input string nm);
        wr_en   = wr;
        rd_en   = rd;
        data_in = din;
`ifdef FIFO_FWFT_EN
        if (chk_rd) begin
            chk({nm, " valid"}, int'(data_valid), 1);
            chk({nm, " data"}, int'(data_o), int'(exp_d));
        end
        step();
`else
        step();
        if (chk_rd) begin
            chk({nm, " valid"}, int'(data_valid), 1);
            chk({nm, " data"}, int'(data_o), int'(exp_d));
        end
`endif
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;

        // Mixed short sequence right after reset (count starts at 0).
        vecs[0] = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 8'h33, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33};
        vecs[7] = '{1'b1, 1'b1, 8'h44, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33};
        vecs[8] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44};

        // Reset state.
        do_reset();
        chk("rst count", int'(count), 0);
        chk("rst empty", int'(empty), 1);
        chk("rst almost_empty", int'(almost_empty), 1);
        chk("rst full", int'(full), 0);
        chk("rst almost_full", int'(almost_full), 0);
        chk("rst data_valid", int'(data_valid), 0);
        chk("rst overflow", int'(overflow), 0);
        chk("rst underflow", int'(underflow), 0);
`ifndef FIFO_FWFT_EN
        chk("rst data_o", int'(data_o), 0);
`endif

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            wr_en   = vecs[i].wr;
            rd_en   = vecs[i].rd;
            data_in = vecs[i].din;
            step();
            chk($sformatf("vec%0d count", i), int'(count), vecs[i].cnt);
            chk($sformatf("vec%0d empty", i), int'(empty), int'(vecs[i].emp));
            chk($sformatf("vec%0d full", i), int'(full), int'(vecs[i].ful));
            chk($sformatf("vec%0d overflow", i), int'(overflow), int'(vecs[i].ovf));
            chk($sformatf("vec%0d underflow", i), int'(underflow), int'(vecs[i].udf));
`ifndef FIFO_FWFT_EN
            chk($sformatf("vec%0d data_valid", i), int'(data_valid), int'(vecs[i].dv));
            chk($sformatf("vec%0d data_o", i), int'(data_o), int'(vecs[i].dout));
`endif
        end
        wr_en = 1'b0;
        rd_en = 1'b0;

        // Fill 0x00..0x3F, watch thresholds and full.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            do_op(1'b1, 1'b0, 8'(i), 1'b0, 8'h00, "fill");
            if (i == 15) chk("ae at 16", int'(almost_empty), 1);
            if (i == 16) chk("ae at 17", int'(almost_empty), 0);
            if (i == 46) chk("af at 47", int'(almost_full), 0);
            if (i == 47) chk("af at 48", int'(almost_full), 1);
            if (i == 62) chk("full at 63", int'(full), 0);
        end
        chk("fill full", int'(full), 1);
        chk("fill count", int'(count), 64);
        do_op(1'b1, 1'b0, 8'hEE, 1'b0, 8'h00, "ovf");
        chk("ovf pulse", int'(overflow), 1);
        chk("ovf count", int'(count), 64);
        do_op(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, "idle");
        chk("ovf cleared", int'(overflow), 0);

        // Drain in order, then one extra read.
        for (int i = 0; i < 64; i++) begin
            do_op(1'b0, 1'b1, 8'h00, 1'b1, 8'(i), $sformatf("drain%0d", i));
        end
        chk("drain empty", int'(empty), 1);
        chk("drain count", int'(count), 0);
        do_op(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, "udf");
        chk("udf pulse", int'(underflow), 1);
        chk("udf data_valid", int'(data_valid), 0);

        // Full with simultaneous read/write, then empty with simultaneous.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            do_op(1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 8'h00, "fill2");
        end
        for (int j = 0; j < 10; j++) begin
            do_op(1'b1, 1'b1, 8'(8'hC0 + j), 1'b1, 8'(8'h80 + j), $sformatf("rwfull%0d", j));
            chk($sformatf("rwfull%0d count", j), int'(count), 64);
            chk($sformatf("rwfull%0d ovf", j), int'(overflow), 0);
        end
        for (int i = 10; i < 64; i++) begin
            do_op(1'b0, 1'b1, 8'h00, 1'b1, 8'(8'h80 + i), $sformatf("drain2_%0d", i));
        end
        for (int j = 0; j < 10; j++) begin
            do_op(1'b0, 1'b1, 8'h00, 1'b1, 8'(8'hC0 + j), $sformatf("drain2c_%0d", j));
        end
        chk("drain2 empty", int'(empty), 1);
        do_op(1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, "rwempty");
        chk("rwempty udf", int'(underflow), 1);
        chk("rwempty count", int'(count), 1);
        do_op(1'b0, 1'b1, 8'h00, 1'b1, 8'h5A, "rwempty rd");
        chk("rwempty final count", int'(count), 0);

        // Pointer wrap: 3 rounds of push 40 / pop 40.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 40; i++) begin
                do_op(1'b1, 1'b0, 8'(r * 40 + i), 1'b0, 8'h00, "wpush");
                if (overflow !== 1'b0) chk("wrap push ovf", int'(overflow), 0);
            end
            chk($sformatf("wrap%0d count40", r), int'(count), 40);
            for (int i = 0; i < 40; i++) begin
                do_op(1'b0, 1'b1, 8'h00, 1'b1, 8'(r * 40 + i), $sformatf("wrap%0d_%0d", r, i));
                if (underflow !== 1'b0) chk("wrap pop udf", int'(underflow), 0);
            end
            chk($sformatf("wrap%0d count0", r), int'(count), 0);
        end

        // Reset mid-stream wins over a write.
        do_reset();
        for (int i = 0; i < 37; i++) begin
            do_op(1'b1, 1'b0, 8'(i), 1'b0, 8'h00, "pre");
        end
        chk("pre count", int'(count), 37);
        reset   = 1'b1;
        wr_en   = 1'b1;
        data_in = 8'hAB;
        step();
        reset = 1'b0;
        wr_en = 1'b0;
        chk("midrst count", int'(count), 0);
        chk("midrst empty", int'(empty), 1);
        do_op(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, "midrst rd");
        chk("midrst udf", int'(underflow), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
